jump_decision_bht: RTL and testbench

- Parametrised successor to the core's jump decision stage: resolves conditional branches, JAL and JALR in EX.
- Produces a registered redirect (flush + target PC) on a mispredict.
- Holds a direct-mapped table of 2-bit saturating counters (BHT). ID reads the BHT to predict conditional branches, computing the target itself.
- Sits between ID/EX and the fetch PC mux.

---
 rtl/jump_decision_bht.sv | 173 +++++++++++++++++
 tb/tb_jump_decision_bht.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_decision_bht.sv
// ---------------------------------------------------------------------------
// jump_decision_bht
//
// EX-stage jump/branch resolver with a direct-mapped table of 2-bit
// saturating counters (BHT) that ID consults to predict conditional branches.
// A mispredict produces a one-cycle registered redirect (or a misaligned-
// target exception when the taken target is not word aligned).
//
// Optional build macro: JUMP_DECISION_STATS_EN adds two saturating 32-bit
// event counters (stat_branches, stat_mispredicts).
//
// Ports:
//   clk, clk_en, rst_n     clock, clock enable, async active-low reset
//   id_pc / id_pred_taken  ID lookup address / combinational prediction
//   ex_*                   resolved EX instruction (type, funct3, operands,
//                          pc, immediate, prediction ID acted on)
//   redirect_valid/_pc     registered flush pulse and new fetch PC
//   misalign_exc           registered misaligned-target pulse
//   stat_branches          (stats build) resolved conditional branches
//   stat_mispredicts       (stats build) redirect + misalign events
// ---------------------------------------------------------------------------
module jump_decision_bht #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            clk_en,
    input  logic            rst_n,
    input  logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign_exc
`ifdef JUMP_DECISION_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Instruction type with priority jalr > jal > branch
    logic is_jalr;
    logic is_jal;
    logic is_br;
    assign is_jalr = ex_is_jalr;
    assign is_jal  = ex_is_jal & ~ex_is_jalr;
    assign is_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;

    logic cond;
    always_comb begin
        cond = 1'b0;
        case (ex_funct3)
            3'b000:  cond = (ex_rs1 == ex_rs2);
            3'b001:  cond = (ex_rs1 != ex_rs2);
            3'b100:  cond = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond = (ex_rs1 <  ex_rs2);
            3'b111:  cond = (ex_rs1 >= ex_rs2);
            default: cond = 1'b0;
        endcase
    end

    logic [XLEN-1:0] sum_pc;
    logic [XLEN-1:0] sum_rs;
    logic [XLEN-1:0] target;
    assign sum_pc = ex_pc + ex_imm;
    assign sum_rs = ex_rs1 + ex_imm;
    assign target = is_jalr ? {sum_rs[XLEN-1:1], 1'b0} : sum_pc;

    logic actual_taken;
    logic eff_pred;
    logic mispredict;
    logic aligned;
    assign actual_taken = is_jalr | is_jal | (is_br & cond);
    // JALR is never predicted, so it always redirects; non-control
    // instructions carry no prediction.
    assign eff_pred     = (is_br | is_jal) & ex_pred_taken;
    assign mispredict   = ex_valid & (actual_taken != eff_pred);
    assign aligned      = (target[1:0] == 2'b00);

    logic            redirect_valid_next;
    logic            misalign_exc_next;
    logic [XLEN-1:0] redirect_pc_next;
    assign redirect_valid_next = mispredict & aligned;
    assign misalign_exc_next   = mispredict & ~aligned & actual_taken;
    assign redirect_pc_next    = actual_taken ? target : (ex_pc + XLEN'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            misalign_exc   <= 1'b0;
            redirect_pc    <= '0;
        end else if (clk_en) begin
            redirect_valid <= redirect_valid_next;
            misalign_exc   <= misalign_exc_next;
            if (redirect_valid_next) begin
                redirect_pc <= redirect_pc_next;
            end
        end
    end

    // BHT: one counter register per entry so every entry can be reset
    // asynchronously; MSBs are gathered into a vector for the ID lookup.
    logic [IDX_W-1:0]       id_idx;
    logic [IDX_W-1:0]       ex_idx;
    logic [BHT_ENTRIES-1:0] bht_msb;
    logic                   bht_we;
    assign id_idx = id_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign bht_we = clk_en & ex_valid & is_br;

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            logic [1:0] cnt_reg;
            logic [1:0] cnt_next;
            always_comb begin
                cnt_next = cnt_reg;
                if (cond) begin
                    if (cnt_reg != 2'b11) cnt_next = cnt_reg + 2'b01;
                end else begin
                    if (cnt_reg != 2'b00) cnt_next = cnt_reg - 2'b01;
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= CNT_INIT;
                end else if (bht_we && (ex_idx == IDX_W'(gi))) begin
                    cnt_reg <= cnt_next;
                end
            end
            assign bht_msb[gi] = cnt_reg[1];
        end
    endgenerate

    // Read-before-write: the lookup sees the counter value from before
    // this edge's update.
    assign id_pred_taken = bht_msb[id_idx];

`ifdef JUMP_DECISION_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (clk_en) begin
            if (ex_valid && is_br && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if ((redirect_valid_next || misalign_exc_next) &&
                (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{id_pc[XLEN-1:IDX_W+2], id_pc[1:0], sum_rs[0]};

endmodule

// File: tb/tb_jump_decision_bht.sv
module tb_jump_decision_bht;

    localparam int NE = 64;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        rst_n;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
    logic        ex_pred_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_exc;
`ifdef JUMP_DECISION_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    jump_decision_bht dut (
        .clk(clk), .clk_en(clk_en), .rst_n(rst_n),
        .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_exc(misalign_exc)
`ifdef JUMP_DECISION_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        upd;
        logic        up;
        logic [31:0] idx;
        logic        rv;
        logic        mis;
        logic [31:0] rpc;
    } step_t;

    function automatic logic [31:0] idx_of(input logic [31:0] pc);
        return (pc / 4) % NE;
    endfunction

    function automatic step_t model_step(
        input logic v, br, jal, jalr, input logic [2:0] f3,
        input logic [31:0] a, b, pc, imm, input logic pred);
        step_t s;
        logic take, actual, eff, misp;
        logic [31:0] tgt;
        case (f3)
            3'd0: take = (a == b);
            3'd1: take = (a != b);
            3'd4: take = ($signed(a) <  $signed(b));
            3'd5: take = ($signed(a) >= $signed(b));
            3'd6: take = (a <  b);
            3'd7: take = (a >= b);
            default: take = 1'b0;
        endcase
        tgt = pc + imm; actual = 1'b0; eff = 1'b0;
        if (jalr) begin
            tgt = (a + imm) & 32'hFFFF_FFFE; actual = 1'b1; eff = 1'b0;
        end else if (jal) begin
            actual = 1'b1; eff = pred;
        end else if (br) begin
            actual = take; eff = pred;
        end
        misp  = v && (actual != eff);
        s.rv  = misp && (tgt % 4 == 0);
        s.mis = misp && (tgt % 4 != 0) && actual;
        s.rpc = actual ? tgt : pc + 4;
        s.upd = v && br && !jal && !jalr;
        s.up  = take;
        s.idx = idx_of(pc);
        return s;
    endfunction

    step_t st;
    always_comb st = model_step(ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
                                ex_funct3, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_pred_taken);

    int          m_cnt [NE];
    logic        m_rv, m_mis;
    logic [31:0] m_rpc;
    logic [31:0] m_sb, m_sm;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) m_cnt[i] <= 1;
            m_rv <= 1'b0; m_mis <= 1'b0; m_rpc <= '0; m_sb <= '0; m_sm <= '0;
        end else if (clk_en) begin
            m_rv  <= st.rv;
            m_mis <= st.mis;
            if (st.rv) m_rpc <= st.rpc;
            if (st.upd) begin
                m_cnt[st.idx] <= st.up ? ((m_cnt[st.idx] == 3) ? 3 : m_cnt[st.idx] + 1)
                                       : ((m_cnt[st.idx] == 0) ? 0 : m_cnt[st.idx] - 1);
                m_sb <= m_sb + 1;
            end
            if (st.rv || st.mis) m_sm <= m_sm + 1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("pred", 32'(id_pred_taken), 32'(m_cnt[idx_of(id_pc)] >= 2));
            chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
            chk("redirect_pc", redirect_pc, m_rpc);
            chk("misalign_exc", 32'(misalign_exc), 32'(m_mis));
`ifdef JUMP_DECISION_STATS_EN
            chk("stat_branches", stat_branches, m_sb);
            chk("stat_mispredicts", stat_mispredicts, m_sm);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic ex(input logic v, br, jal, jalr, input logic [2:0] f3,
                      input logic [31:0] a, b, pc, imm, input logic pred);
        ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
        ex_pred_taken = pred;
        $display("txn t=%0t en=%0b v=%0b br=%0b jal=%0b jalr=%0b f3=%0d rs1=%h rs2=%h pc=%h imm=%h pred=%0b id_pc=%h",
                 $time, clk_en, v, br, jal, jalr, f3, a, b, pc, imm, pred, id_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic chk_out(input string nm, input logic rv, input logic [31:0] rpc, input logic mis);
        chk({nm, ".rv"}, 32'(redirect_valid), 32'(rv));
        chk({nm, ".rpc"}, redirect_pc, rpc);
        chk({nm, ".mis"}, 32'(misalign_exc), 32'(mis));
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; id_pc = 32'h100;
        idle();
        tick(); tick();
        rst_n = 1'b1;
        cmp_on = 1'b1;

        // Reset state: every index weakly not-taken, outputs clear
        chk_out("reset", 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < NE; i++) begin
            id_pc = 32'(i * 4);
            #1 chk("reset_pred", 32'(id_pred_taken), 32'd0);
        end
        id_pc = 32'h100;

        // BEQ taken, predicted not taken -> redirect to pc+imm, counter 01->10
        ex(1, 1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h40, 1'b0);
        tick(); chk_out("beq", 1'b1, 32'h140, 1'b0);
        chk("beq_pred", 32'(id_pred_taken), 32'd1);

        // Signed vs unsigned compare of the same operands
        ex(1, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
        tick(); chk_out("blt", 1'b1, 32'h210, 1'b0);
        ex(1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b0);
        tick(); chk_out("bltu_nt", 1'b0, 32'h210, 1'b0);
        ex(1, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b1);
        tick(); chk_out("bltu_pc4", 1'b1, 32'h304, 1'b0);
        chk("idx0_pred", 32'(id_pred_taken), 32'd0);

        // JALR: bit0 cleared, aligned and misaligned targets
        ex(1, 0, 0, 1, 3'b000, 32'h205, 32'h0, 32'h400, 32'h0, 1'b1);
        tick(); chk_out("jalr_bit0", 1'b1, 32'h204, 1'b0);
        ex(1, 0, 0, 1, 3'b000, 32'h206, 32'h0, 32'h400, 32'h0, 1'b0);
        tick(); chk_out("jalr_mis", 1'b0, 32'h204, 1'b1);
        ex(1, 0, 0, 1, 3'b000, 32'h1F0, 32'h0, 32'h400, 32'h11, 1'b0);
        tick(); chk_out("jalr_imm", 1'b1, 32'h200, 1'b0);

        // JAL: correctly predicted, then mispredicted with misaligned target
        ex(1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h500, 32'h100, 1'b1);
        tick(); chk_out("jal_ok", 1'b0, 32'h200, 1'b0);
        ex(1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h500, 32'h102, 1'b0);
        tick(); chk_out("jal_mis", 1'b0, 32'h200, 1'b1);

        // All type bits set: JALR wins, BHT at idx 6 untouched
        id_pc = 32'h18;
        ex(1, 1, 1, 1, 3'b000, 32'h300, 32'h300, 32'h18, 32'h10, 1'b1);
        tick(); chk_out("prio", 1'b1, 32'h310, 1'b0);
        chk("prio_pred", 32'(id_pred_taken), 32'd0);
        // Invalid EX slot: no redirect, no update
        ex(0, 1, 0, 0, 3'b000, 32'h1, 32'h1, 32'h18, 32'h10, 1'b0);
        tick(); chk_out("invalid", 1'b0, 32'h310, 1'b0);
        chk("invalid_pred", 32'(id_pred_taken), 32'd0);

        // Saturation at index 5
        id_pc = 32'h14;
        for (int k = 0; k < 4; k++) begin
            ex(1, 1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h14, 32'h8, 1'b1);
            tick(); chk("sat_up", 32'(id_pred_taken), 32'd1);
        end
        ex(1, 1, 0, 0, 3'b001, 32'h7, 32'h7, 32'h14, 32'h8, 1'b0);
        tick(); chk("sat_top_no_wrap", 32'(id_pred_taken), 32'd1);
        for (int k = 0; k < 4; k++) begin
            ex(1, 1, 0, 0, 3'b001, 32'h7, 32'h7, 32'h14, 32'h8, 1'b0);
            tick(); chk("sat_down", 32'(id_pred_taken), 32'd0);
        end
        ex(1, 1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h14, 32'h8, 1'b1);
        tick(); chk("sat_bot_no_wrap", 32'(id_pred_taken), 32'd0);
        ex(1, 1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h14, 32'h8, 1'b0);
        tick(); chk_out("sat_redir", 1'b1, 32'h1C, 1'b0);
        chk("sat_10", 32'(id_pred_taken), 32'd1);

        // clk_en low: everything holds, redirect pulse stretches
        clk_en = 1'b0;
        ex(1, 1, 0, 0, 3'b001, 32'h7, 32'h7, 32'h14, 32'h8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(); chk_out("hold", 1'b1, 32'h1C, 1'b0);
            chk("hold_pred", 32'(id_pred_taken), 32'd1);
        end
        clk_en = 1'b1;
        tick(); chk_out("resume", 1'b1, 32'h18, 1'b0);
        chk("resume_pred", 32'(id_pred_taken), 32'd0);

        // Asynchronous reset in the cycle after a mispredict
        ex(1, 1, 0, 0, 3'b000, 32'h7, 32'h7, 32'h14, 32'h8, 1'b0);
        tick(); chk_out("pre_rst", 1'b1, 32'h1C, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 1'b0, 32'h0, 1'b0);
        chk("async_rst_pred", 32'(id_pred_taken), 32'd0);
`ifdef JUMP_DECISION_STATS_EN
        chk("rst_stat_b", stat_branches, 32'd0);
        chk("rst_stat_m", stat_mispredicts, 32'd0);
`endif
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            logic [31:0] pc, a, b, imm;
            int ty;
            logic pr;
            clk_en = ($urandom_range(0, 9) != 0);
            ty  = $urandom_range(0, 3);
            pc  = 32'($urandom_range(0, 255)) * 4;
            id_pc = ($urandom_range(0, 3) == 0) ? pc : 32'($urandom_range(0, 255)) * 4;
            a   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7)) - 32'd4;
            b   = ($urandom_range(0, 2) == 0) ? a
                : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 7)) - 32'd4);
            pr  = 1'($urandom_range(0, 1));
            case (ty)
                1:       begin imm = $urandom & 32'hFFFF_FFFC;
                               ex(1'($urandom_range(0, 4) != 0), 1, 0, 0, 3'($urandom_range(0, 7)), a, b, pc, imm, pr); end
                2:       begin imm = $urandom & 32'hFFFF_FFFE;
                               ex(1'($urandom_range(0, 4) != 0), 0, 1, 0, 3'($urandom_range(0, 7)), a, b, pc, imm, pr); end
                3:       begin imm = $urandom;
                               ex(1'($urandom_range(0, 4) != 0), 0, 0, 1, 3'($urandom_range(0, 7)), a, b, pc, imm, pr); end
                default: ex(1'($urandom_range(0, 1)), 0, 0, 0, 3'($urandom_range(0, 7)), a, b, pc, $urandom, 1'b0);
            endcase
            tick();
        end

        idle();
        tick();
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
